// File: rtl/lcg_random.sv
// 31-bit linear-congruential random source with pre-decoded game fields.
// Optional seed load port is enabled by defining LCG_SEED_LOAD_EN.
module lcg_random #(
    parameter logic [30:0] SEED = 31'd879387228,
    parameter logic [30:0] MULT = 31'd1103515245,
    parameter logic [30:0] INC  = 31'd12345
) (
    input  logic        clk,
    input  logic        restart_n,
    input  logic        next,
`ifdef LCG_SEED_LOAD_EN
    input  logic        seed_load,
    input  logic [30:0] seed_in,
`endif
    output logic [30:0] rand_out,
    output logic        valid,
    output logic [7:0]  sq_width,
    output logic [7:0]  gap,
    output logic        rbit
);

    typedef enum logic {IDLE, RUN} mode_t;

    mode_t       mode_q, mode_d;
    logic [30:0] state_q, state_d;
    logic [30:0] product;

    // Only the low 31 product bits matter, so the multiply is sized to 31 bits.
    assign product = state_q * MULT;

    always_ff @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            state_q <= SEED;
            mode_q  <= IDLE;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
`ifdef LCG_SEED_LOAD_EN
        if (seed_load) begin
            state_d = seed_in;
            mode_d  = IDLE;
        end else
`endif
        if (next) begin
            state_d = product + INC;
            mode_d  = RUN;
        end
    end

    always_comb begin
        sq_width = 8'd9;
        if (state_q[4:0] < 5'd4)
            sq_width = 8'd5;
        else if (state_q[4:0] < 5'd10)
            sq_width = 8'd6;
        else if (state_q[4:0] < 5'd23)
            sq_width = 8'd7;
        else if (state_q[4:0] < 5'd29)
            sq_width = 8'd8;
    end

    assign rand_out = state_q;
    assign valid    = (mode_q == RUN);
    assign gap      = 8'd13 + {5'd0, state_q[2:0]};
    assign rbit     = state_q[0];

endmodule

// File: tb/tb_lcg_random.sv
// Self-checking bench for lcg_random against a 64-bit arithmetic reference model.
// Seed-load checks are compiled only when LCG_SEED_LOAD_EN is defined.
module tb_lcg_random;

    localparam longint unsigned SEED_V = 64'd879387228;
    localparam longint unsigned MULT_V = 64'd1103515245;
    localparam longint unsigned INC_V  = 64'd12345;

    logic        clk = 1'b0;
    logic        restart_n;
    logic        next;
`ifdef LCG_SEED_LOAD_EN
    logic        seed_load;
    logic [30:0] seed_in;
`endif
    logic [30:0] rand_out;
    logic        valid;
    logic [7:0]  sq_width;
    logic [7:0]  gap;
    logic        rbit;

    int total = 0;
    int bad   = 0;

    longint unsigned model_state;
    bit              model_valid;

    lcg_random dut (
        .clk       (clk),
        .restart_n (restart_n),
        .next      (next),
`ifdef LCG_SEED_LOAD_EN
        .seed_load (seed_load),
        .seed_in   (seed_in),
`endif
        .rand_out  (rand_out),
        .valid     (valid),
        .sq_width  (sq_width),
        .gap       (gap),
        .rbit      (rbit)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned lcg_step(longint unsigned s);
        return (s * MULT_V + INC_V) % 64'h8000_0000;
    endfunction

    function automatic longint unsigned width_of(longint unsigned s);
        longint unsigned low = s % 32;
        if (low < 4)  return 5;
        if (low < 10) return 6;
        if (low < 23) return 7;
        if (low < 29) return 8;
        return 9;
    endfunction

    task automatic check_output(string tag, longint unsigned observed, longint unsigned expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_all(string tag);
        check_output({tag, ".rand"},  longint'(rand_out), model_state);
        check_output({tag, ".valid"}, longint'(valid), longint'(model_valid));
        check_output({tag, ".width"}, longint'(sq_width), width_of(model_state));
        check_output({tag, ".gap"},   longint'(gap), 13 + (model_state % 8));
        check_output({tag, ".rbit"},  longint'(rbit), model_state % 2);
    endtask

    // One clock: drive at negedge, update model at posedge, sample at next negedge.
    task automatic apply_stimulus(bit nx, bit ld, logic [30:0] sd);
        next = nx;
`ifdef LCG_SEED_LOAD_EN
        seed_load = ld;
        seed_in   = sd;
`endif
        @(posedge clk);
        if (restart_n) begin
            if (ld) begin
                model_state = longint'(sd);
                model_valid = 1'b0;
            end else if (nx) begin
                model_state = lcg_step(model_state);
                model_valid = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        restart_n = 1'b0;
        next      = 1'b0;
`ifdef LCG_SEED_LOAD_EN
        seed_load = 1'b0;
        seed_in   = '0;
`endif
        model_state = SEED_V;
        model_valid = 1'b0;
        #12;
        check_all("reset");
        @(negedge clk);
        restart_n = 1'b1;

        // First step against the published values.
        apply_stimulus(1'b1, 1'b0, '0);
        check_output("first.rand", longint'(rand_out), 711727461);
        check_output("first.valid", longint'(valid), 1);
        check_output("first.width", longint'(sq_width), 6);
        check_output("first.gap", longint'(gap), 18);
        check_output("first.rbit", longint'(rbit), 1);
        check_all("first");

        for (int i = 0; i < 1000; i++) begin
            apply_stimulus(1'b1, 1'b0, '0);
            check_all("run");
        end

        for (int i = 0; i < 300; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), 1'b0, '0);
            check_all("rnd");
        end

        for (int i = 0; i < 50; i++) begin
            apply_stimulus(1'b0, 1'b0, '0);
            check_all("hold");
        end

        // Asynchronous reset between edges, then held across an edge with next high.
        next = 1'b1;
        #2;
        restart_n = 1'b0;
        #1;
        model_state = SEED_V;
        model_valid = 1'b0;
        check_all("async_rst");
        @(negedge clk);
        apply_stimulus(1'b1, 1'b0, '0);
        check_all("rst_held");
        restart_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, 1'b0, '0);
            check_all("restart");
        end
        check_output("restart.first20_rand_valid", longint'(valid), 1);

`ifdef LCG_SEED_LOAD_EN
        begin
            logic [4:0] lows [10] = '{5'd0, 5'd3, 5'd4, 5'd9, 5'd10, 5'd22, 5'd23, 5'd28, 5'd29, 5'd31};
            for (int i = 0; i < 10; i++) begin
                logic [25:0] hi;
                hi = 26'($urandom);
                apply_stimulus(1'b1, 1'b1, {hi, lows[i]});
                check_all("load");
            end
        end
        apply_stimulus(1'b1, 1'b1, 31'd0);
        check_output("load0.rand", longint'(rand_out), 0);
        check_output("load0.valid", longint'(valid), 0);
        apply_stimulus(1'b1, 1'b0, '0);
        check_output("load0.step", longint'(rand_out), 12345);
        check_all("load0");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcg_random.md
# lcg_random

Pseudo-random source for the BottleFlip game logic. It produces a 31-bit linear-congruential sequence in hardware, along with pre-decoded game fields: square width, gap distance and a layout/colour bit. The game FSM pulses `next` whenever it needs a fresh draw, and reads the registered outputs on the following cycle.

## Interface
Parameters:
- `SEED`, default 879387228: state loaded on reset (31-bit).
- `MULT`, default 1103515245: LCG multiplier.
- `INC`, default 12345: LCG increment.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `restart_n`, input, 1: reset, asynchronous, active-low.
- `next`, input, 1: advance the generator one step.
- `rand_out`, output, 31: current generator state.
- `valid`, output, 1: high once at least one step has completed since reset or load.
- `sq_width`, output, 8: square width decoded from `rand_out[4:0]`.
- `gap`, output, 8: `13 + rand_out[2:0]`, range 13..20.
- `rbit`, output, 1: `rand_out[0]`, used as the layout/colour bit.
- `seed_load`, input, 1: only present with `LCG_SEED_LOAD_EN`.
- `seed_in`, input, 31: only present with `LCG_SEED_LOAD_EN`.

## Operation
- Step function: `state' = (state*MULT + INC) mod 2^31`.
  - Full product truncated to the low 31 bits.
  - No saturation.
  - Wrap-around is inherent.
- `sq_width` decode of `s = rand_out[4:0]`:
  - s<4 → 5
  - s<10 → 6
  - s<23 → 7
  - s<29 → 8
  - otherwise → 9
  - s=0 decodes to 5; width 4 is never produced.
- `sq_width`, `gap` and `rbit` are combinational from the state register.
  - They are always consistent with `rand_out` in the same cycle.
- No handshake back-pressure: every cycle with `next`=1 advances once.
  - `next` held high advances every cycle.
- No internal FSM beyond the `valid` flag.
  - IDLE (`valid`=0) → on first step → RUN (`valid`=1).
  - RUN stays in RUN until reset or load.

## Timing
- Reset (`restart_n`=0, asynchronous):
  - `rand_out` = `SEED`
  - `valid` = 0
  - `sq_width`/`gap`/`rbit` are decoded from `SEED`.
- Latency: `next` sampled at edge N gives the new `rand_out` and `valid`=1 after edge N; one cycle.
- Reset asserted mid-sequence: the state returns to `SEED` immediately, without waiting for a clock edge.
- Reset deasserted while `next`=1: no step occurs on an edge where `restart_n` is still low.
- Step datapath: a single-cycle 31×31 multiply.
  - Only the low 31 product bits need be formed.

## Configuration
- `LCG_SEED_LOAD_EN` defined:
  - Ports `seed_load` and `seed_in` exist.
  - `seed_load`=1 at an edge sets state = `seed_in` and `valid`=0, with no step applied.
  - `seed_load` has priority over a simultaneous `next`.
- `LCG_SEED_LOAD_EN` undefined:
  - The ports are absent.
  - The state changes only by reset and `next`.

## Test plan
- Reset → `rand_out`=879387228 and `valid`=0; pulse `next` once → `rand_out`=711727461, `valid`=1, `sq_width`=6, `gap`=18, `rbit`=1.
- Hold `next` high for 1000 cycles → every `rand_out` matches a software model of `(s*1103515245+12345)&0x7fffffff`; bit 31 never set.
- Force `rand_out[4:0]` through 0, 3, 4, 9, 10, 22, 23, 28, 29, 31 (via seed load) → `sq_width` is 5, 5, 6, 6, 7, 7, 8, 8, 9, 9, and `gap` = 13 + low 3 bits.
- Assert `restart_n` low mid-run, between clock edges → `rand_out` returns to 879387228 and `valid` drops before the next edge; the sequence restarts identically.
- With `LCG_SEED_LOAD_EN`: `seed_load`=1 with `seed_in`=0 and `next`=1 in the same cycle → `rand_out`=0 and `valid`=0; a following `next` → `rand_out`=12345.
- `next`=0 for 50 cycles → `rand_out` is stable and `valid` is unchanged.
